// File: rtl/serial_add_arbiter_if.sv
// serial_add_arbiter_if
//   Bundles the request/operand side and the result side of the two-requester
//   serial adder into one bus.
//   Requester side : req0/req1 (level request, held until ack), a0/b0/cin0 and
//                    a1/b1/cin1 (operands, stable while the matching req is high).
//   Adder side     : ack0/ack1 (one-cycle accept pulses), y/carryout/owner
//                    (result of the last completed operation), done (one-cycle
//                    pulse when results update), busy (operation in progress).
//   Handshake: a request is a level on reqN; it is consumed on the clock edge
//   that raises ackN for the following cycle, and the operands are captured on
//   that same edge. Results are valid in the cycle done is high and hold until
//   the next done pulse.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin0;
    logic             cin1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] y;
    logic             carryout;
    logic             owner;
    logic             done;
    logic             busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, cin0, cin1,
        input  ack0, ack1, y, carryout, owner, done, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cin0, cin1,
        output ack0, ack1, y, carryout, owner, done, busy
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//   Round-robin arbiter in front of a bit-serial adder. One of two requesters
//   is granted, its operands are added one bit per clock (LSB first) and the
//   WIDTH-bit sum, carry-out and owner index are published with a done pulse.
//   Ports:
//     clk         : sole clock, all state changes on posedge
//     rst         : synchronous active-low reset
//     bus         : serial_add_arbiter_if.slave (requests, operands, results)
//     o_dbg_state : current FSM state, for observation only
module serial_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_arbiter_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic             r_grant;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_carryout;
    logic             r_owner;
    logic             r_ack0;
    logic             r_ack1;

    logic             w_any_req;
    logic             w_grant_idx;
    logic             w_s;
    logic             w_c_next;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_sum_next;

    assign w_any_req   = bus.req0 | bus.req1;
    // With both requesting the one that did not win last time goes; otherwise
    // the sole requester wins (req1 alone -> 1, req0 alone -> 0).
    assign w_grant_idx = (bus.req0 & bus.req1) ? ~r_last_grant : bus.req1;

    assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_c_next   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
    assign w_last_bit = (r_cnt == LAST_BIT);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign w_sum_next = WIDTH'({w_s, r_sum} >> 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ADD;
            ADD:     if (w_last_bit) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_c          <= 1'b0;
            r_y          <= '0;
            r_carryout   <= 1'b0;
            r_owner      <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_a_sh       <= w_grant_idx ? bus.a1 : bus.a0;
                        r_b_sh       <= w_grant_idx ? bus.b1 : bus.b0;
                        r_c          <= w_grant_idx ? bus.cin1 : bus.cin0;
                        r_sum        <= '0;
                        r_cnt        <= '0;
                        r_ack0       <= ~w_grant_idx;
                        r_ack1       <= w_grant_idx;
                    end
                end
                ADD: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_c    <= w_c_next;
                    r_sum  <= w_sum_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last_bit) begin
                        r_y        <= w_sum_next;
                        r_carryout <= w_c_next;
                        r_owner    <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.y        = r_y;
    assign bus.carryout = r_carryout;
    assign bus.owner    = r_owner;
    assign bus.done     = (r_state == DONE);
    assign bus.busy     = (r_state != IDLE);
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_rst;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int g_ack_cyc = 0;
  int g_done_cyc = 0;
  int prev_ack;
  int prev_done;
  bit m_last;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference rule for the round-robin grant
  function automatic bit pick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  // driver tasks
  task automatic rand_ops(input int who);
    if (who == 0) begin
      bus.a0 = W'($urandom_range(0, (1 << W) - 1));
      bus.b0 = W'($urandom_range(0, (1 << W) - 1));
      bus.cin0 = 1'($urandom_range(0, 1));
    end else begin
      bus.a1 = W'($urandom_range(0, (1 << W) - 1));
      bus.b1 = W'($urandom_range(0, (1 << W) - 1));
      bus.cin1 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_ops(input int who, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (who == 0) begin bus.a0 = a; bus.b0 = b; bus.cin0 = c; end
    else          begin bus.a1 = a; bus.b1 = b; bus.cin1 = c; end
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack0 || bus.ack1) got = 1'b1;
    end
  endtask

  // Serve one request: wait for the accept pulse, check who won, then check
  // the done timing and the result against plain integer addition.
  task automatic serve(input bit who, input bit keep, input bit late1, input string tag);
    logic [W:0] exp_sum;
    bit got;
    if (who == 0) exp_sum = {1'b0, bus.a0} + {1'b0, bus.b0} + {{W{1'b0}}, bus.cin0};
    else          exp_sum = {1'b0, bus.a1} + {1'b0, bus.b1} + {{W{1'b0}}, bus.cin1};
    wait_ack(got);
    chk({tag, "_ack_seen"}, 32'(got), 1);
    if (!got) return;
    g_ack_cyc = cyc;
    chk({tag, "_ack0"}, 32'(bus.ack0), 32'(who == 0));
    chk({tag, "_ack1"}, 32'(bus.ack1), 32'(who == 1));
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    m_last = who;
    // operands of the served requester change while its add runs
    rand_ops(int'(who));
    if (!keep) begin
      if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    end
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      if (late1 && k == 2) begin
        bus.req1 = 1'b1;
        rand_ops(1);
      end
      if (k == 1) chk({tag, "_dbg_busy"}, 32'(dbg_state != dbg_rst), 1);
      chk({tag, "_no_ack"}, 32'(bus.ack0 | bus.ack1), 0);
      if (k < W) chk({tag, "_done_early"}, 32'(bus.done), 0);
    end
    g_done_cyc = cyc;
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_y"}, 32'(bus.y), 32'(exp_sum[W-1:0]));
    chk({tag, "_cout"}, 32'(bus.carryout), 32'(exp_sum[W]));
    chk({tag, "_owner"}, 32'(bus.owner), 32'(who));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 0);
    chk({tag, "_y_hold"}, 32'(bus.y), 32'(exp_sum[W-1:0]));
    chk({tag, "_idle"}, 32'(bus.busy), 0);
    chk({tag, "_dbg_idle"}, 32'(dbg_state), 32'(dbg_rst));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    m_last = 1'b1;
  endtask

  initial begin
    bit got;
    bit w;
    int pat;
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    set_ops(0, '0, '0, 1'b0);
    set_ops(1, '0, '0, 1'b0);
    m_last = 1'b1;

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    dbg_rst = dbg_state;
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_cout", 32'(bus.carryout), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'({bus.ack0, bus.ack1}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // single request
    set_ops(0, 4'b0101, 4'b0011, 1'b0);
    bus.req0 = 1'b1;
    serve(0, 0, 0, "single");
    chk("single_y_const", 32'(bus.y), 32'(4'b1000));
    chk("single_cout_const", 32'(bus.carryout), 0);

    // simultaneous requests after reset
    do_reset();
    set_ops(0, 4'b1111, 4'b0001, 1'b0);
    set_ops(1, 4'b0111, 4'b1000, 1'b1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    serve(pick(1, 1, m_last), 0, 0, "simul_a");
    chk("simul_a_owner_const", 32'(bus.owner), 0);
    chk("simul_a_cout_const", 32'(bus.carryout), 1);
    prev_done = g_done_cyc;
    serve(1, 0, 0, "simul_b");
    chk("simul_b_gap", 32'(g_ack_cyc - prev_done), 2);
    chk("simul_b_y_const", 32'(bus.y), 0);
    chk("simul_b_cout_const", 32'(bus.carryout), 1);

    // continuous requests: grants alternate, one op every W+2 cycles
    rand_ops(0); rand_ops(1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev_ack = g_ack_cyc;
      w = pick(1, 1, m_last);
      chk("cont_alternate", 32'(w), 32'(i % 2));
      serve(w, 1, 0, "cont");
      if (i > 0) chk("cont_period", 32'(g_ack_cyc - prev_ack), W + 2);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #1;

    // late request during requester 0's add
    rand_ops(0);
    bus.req0 = 1'b1;
    serve(0, 0, 1, "late0");
    prev_done = g_done_cyc;
    serve(1, 0, 0, "late1");
    chk("late1_gap", 32'(g_ack_cyc - prev_done), 2);

    // reset two edges into an add
    rand_ops(0);
    bus.req0 = 1'b1;
    wait_ack(got);
    chk("rstmid_ack_seen", 32'(got), 1);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_outs", 32'({bus.y, bus.carryout, bus.owner, bus.done, bus.busy, bus.ack0, bus.ack1}), 0);
    rst = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_done", 32'({bus.done, bus.busy}), 0);
    end
    set_ops(0, 4'b0001, 4'b0001, 1'b0);
    bus.req0 = 1'b1;
    serve(0, 0, 0, "after_rst");
    chk("after_rst_y_const", 32'(bus.y), 32'(4'b0010));

    // carry boundaries
    set_ops(0, 4'b0000, 4'b0000, 1'b1);
    bus.req0 = 1'b1;
    serve(0, 0, 0, "cin_only");
    chk("cin_only_y_const", 32'(bus.y), 32'(4'b0001));
    chk("cin_only_cout_const", 32'(bus.carryout), 0);
    set_ops(1, 4'b1111, 4'b1111, 1'b1);
    bus.req1 = 1'b1;
    serve(1, 0, 0, "all_ones");
    chk("all_ones_y_const", 32'(bus.y), 32'(4'b1111));
    chk("all_ones_cout_const", 32'(bus.carryout), 1);

    // randomized request patterns
    for (int i = 0; i < 16; i++) begin
      pat = $urandom_range(1, 3);
      rand_ops(0); rand_ops(1);
      bus.req0 = pat[0];
      bus.req1 = pat[1];
      w = pick(pat[0], pat[1], m_last);
      serve(w, 0, 0, "rand");
      if (pat == 3) serve(!w, 0, 0, "rand_2nd");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
